// File: rtl/board_renderer_if.sv
// Redraw handshake and framebuffer write port of the board renderer.
interface board_renderer_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [23:0] wr_data;

    modport master (input start, output busy, output done, output wr_en, output wr_addr, output wr_data);
    modport slave  (output start, input busy, input done, input wr_en, input wr_addr, input wr_data);
endinterface

// File: rtl/board_renderer.sv
// Rasterises a latched N x N board plus cursor into a framebuffer, one pixel per cycle.
// Define BOARD_RENDERER_AUTO_REDRAW_EN to also redraw when board/cursor differ from the last snapshot.
module board_renderer #(
    parameter int N         = 8,
    parameter int CELL_BITS = 3,
    parameter int CELL_PX   = 15,
    parameter int FB_WIDTH  = 160,
    parameter int X_OFF     = 20,
    parameter int Y_OFF     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N*N*CELL_BITS-1:0] board,
    input  logic [3:0]               cursor_x,
    input  logic [3:0]               cursor_y,
    board_renderer_if.master         bus
);
    localparam int SPAN = N * CELL_PX;
    localparam int CW   = $clog2(SPAN);
    localparam int LW   = $clog2(CELL_PX);
    localparam int BW   = N * N * CELL_BITS;
    localparam int SW   = $clog2(BW);
    localparam int K_LO = 2 * CELL_PX / 5;
    localparam int K_HI = CELL_PX - 1 - K_LO;
    localparam int B_LO = CELL_PX / 5;
    localparam int B_HI = CELL_PX - 1 - B_LO;
    localparam logic [14:0] ROW0 = 15'(Y_OFF * FB_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SCAN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     px_q, px_d, py_q, py_d;
    logic [LW-1:0]     lx_q, lx_d, ly_q, ly_d;
    logic [3:0]        cx_q, cx_d, cy_q, cy_d;
    logic [SW-1:0]     cell_row_q, cell_row_d, cx_off_q, cx_off_d;
    logic [14:0]       row_base_q, row_base_d, addr_hold_q, addr_hold_d;
    logic [23:0]       data_hold_q, data_hold_d;
    logic [BW-1:0]     snap_q, snap_d;
    logic [3:0]        cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic              go;
    logic [SW-1:0]     sel;
    logic [CELL_BITS-1:0] code;
    logic              on_border, on_cursor;
    logic [14:0]       live_addr;
    logic [23:0]       live_data;

    function automatic logic in_band(input logic [LW-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

    // Priority below the cursor border: king marker, piece body, then the checkered square.
    function automatic logic [23:0] cell_colour(input logic [CELL_BITS-1:0] c, input logic in_king,
                                                input logic in_body, input logic dark_sq);
        logic king, red, black;
        king  = (c == CELL_BITS'(3)) || (c == CELL_BITS'(4));
        red   = (c == CELL_BITS'(1)) || (c == CELL_BITS'(3));
        black = (c == CELL_BITS'(2)) || (c == CELL_BITS'(4));
        if (king && in_king)       return 24'hFFD700;
        else if (red && in_body)   return 24'hFF0000;
        else if (black && in_body) return 24'h202020;
        else if (dark_sq)          return 24'hB58863;
        else                       return 24'hF0D9B5;
    endfunction

`ifdef BOARD_RENDERER_AUTO_REDRAW_EN
    assign go = bus.start || (board != snap_q) || (cursor_x != cur_x_q) || (cursor_y != cur_y_q);
`else
    assign go = bus.start;
`endif

    assign sel       = cell_row_q + cx_off_q;
    assign code      = snap_q[sel +: CELL_BITS];
    assign on_border = (lx_q == '0) || (lx_q == LW'(CELL_PX - 1)) ||
                       (ly_q == '0) || (ly_q == LW'(CELL_PX - 1));
    assign on_cursor = (cur_x_q < 4'(N)) && (cur_y_q < 4'(N)) &&
                       (cx_q == cur_x_q) && (cy_q == cur_y_q) && on_border;
    assign live_addr = row_base_q + 15'(X_OFF) + 15'(px_q);
    assign live_data = on_cursor ? 24'h00FF00 :
                       cell_colour(code, in_band(lx_q, K_LO, K_HI) && in_band(ly_q, K_LO, K_HI),
                                   in_band(lx_q, B_LO, B_HI) && in_band(ly_q, B_LO, B_HI),
                                   cx_q[0] ^ cy_q[0]);

    always_comb begin
        state_d     = state_q;
        px_d        = px_q;
        py_d        = py_q;
        lx_d        = lx_q;
        ly_d        = ly_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        cell_row_d  = cell_row_q;
        cx_off_d    = cx_off_q;
        row_base_d  = row_base_q;
        addr_hold_d = addr_hold_q;
        data_hold_d = data_hold_q;
        snap_d      = snap_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        case (state_q)
            S_IDLE: if (go) state_d = S_LATCH;
            S_LATCH: begin
                snap_d     = board;
                cur_x_d    = cursor_x;
                cur_y_d    = cursor_y;
                px_d       = '0;
                py_d       = '0;
                lx_d       = '0;
                ly_d       = '0;
                cx_d       = '0;
                cy_d       = '0;
                cell_row_d = '0;
                cx_off_d   = '0;
                row_base_d = ROW0;
                state_d    = S_SCAN;
            end
            S_SCAN: begin
                addr_hold_d = live_addr;
                data_hold_d = live_data;
                // Row wrap: all per-row counters restart, row base steps by one framebuffer pitch.
                if (px_q == CW'(SPAN - 1)) begin
                    px_d       = '0;
                    lx_d       = '0;
                    cx_d       = '0;
                    cx_off_d   = '0;
                    row_base_d = row_base_q + 15'(FB_WIDTH);
                    if (py_q == CW'(SPAN - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        py_d = py_q + CW'(1);
                        if (ly_q == LW'(CELL_PX - 1)) begin
                            ly_d       = '0;
                            cy_d       = cy_q + 4'd1;
                            cell_row_d = cell_row_q + SW'(N * CELL_BITS);
                        end else begin
                            ly_d = ly_q + LW'(1);
                        end
                    end
                end else begin
                    px_d = px_q + CW'(1);
                    if (lx_q == LW'(CELL_PX - 1)) begin
                        lx_d     = '0;
                        cx_d     = cx_q + 4'd1;
                        cx_off_d = cx_off_q + SW'(CELL_BITS);
                    end else begin
                        lx_d = lx_q + LW'(1);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            px_q        <= '0;
            py_q        <= '0;
            lx_q        <= '0;
            ly_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            cell_row_q  <= '0;
            cx_off_q    <= '0;
            row_base_q  <= '0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
            snap_q      <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            px_q        <= px_d;
            py_q        <= py_d;
            lx_q        <= lx_d;
            ly_q        <= ly_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            cell_row_q  <= cell_row_d;
            cx_off_q    <= cx_off_d;
            row_base_q  <= row_base_d;
            addr_hold_q <= addr_hold_d;
            data_hold_q <= data_hold_d;
            snap_q      <= snap_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.wr_en   = (state_q == S_SCAN);
    assign bus.wr_addr = (state_q == S_SCAN) ? live_addr : addr_hold_q;
    assign bus.wr_data = (state_q == S_SCAN) ? live_data : data_hold_q;
endmodule

// File: doc/board_renderer.md
BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 SHALL have parameter N, default 8: board dimension, N x N cells, 2..15.
REQ-002 SHALL have parameter CELL_BITS, default 3: status bits per cell.
REQ-003 SHALL have parameter CELL_PX, default 15: virtual pixels per cell side, at least 5.
REQ-004 SHALL have parameter FB_WIDTH, default 160: framebuffer row pitch in words.
REQ-005 SHALL have parameters X_OFF, default 20, and Y_OFF, default 0: board origin in the framebuffer.
REQ-006 SHALL have port clk, input, 1: sole clock.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port board, input, N*N*CELL_BITS: cell (cx,cy) is board[(cy*N+cx)*CELL_BITS +: CELL_BITS], 0-based.
REQ-009 SHALL have ports cursor_x and cursor_y, input, 4 each: highlighted cell.
REQ-010 SHALL have port start, input, 1: redraw request, sampled only in IDLE.
REQ-011 SHALL have port busy, output, 1: high in LATCH, SCAN and DONE.
REQ-012 SHALL have port done, output, 1: one-cycle pulse at end of redraw.
REQ-013 SHALL have port wr_addr, output, 15: framebuffer word address.
REQ-014 SHALL have port wr_data, output, 24: RGB888 pixel data.
REQ-015 SHALL have port wr_en, output, 1: write strobe, one pixel per cycle.

Function
REQ-016 SHALL implement the FSM IDLE -> LATCH -> SCAN -> DONE -> IDLE.
- IDLE exits on start.
- LATCH lasts 1 cycle.
- SCAN lasts (N*CELL_PX)^2 cycles.
- DONE lasts 1 cycle.
REQ-017 SHALL snapshot board, cursor_x and cursor_y in LATCH; input changes during SCAN SHALL NOT affect the frame being drawn.
REQ-018 SHALL ignore start in LATCH, SCAN and DONE (no queuing).
REQ-019 SHALL scan in raster order with pixel px fastest and py slowest, both 0..N*CELL_PX-1, wr_en=1 on every SCAN cycle.
REQ-020 SHALL output wr_addr = (Y_OFF+py)*FB_WIDTH + X_OFF + px, built from incremental counters only (row base += FB_WIDTH on row wrap); no multiplier.
REQ-021 SHALL compute cell (cx,cy) = (px/CELL_PX, py/CELL_PX) and local (lx,ly) = (px%CELL_PX, py%CELL_PX) from wrapping sub-counters; no divider.
REQ-022 SHALL select pixel colour by priority, highest first:
- (a) cursor border: cell equals snapshot cursor and lx or ly is 0 or CELL_PX-1 -> 24'h00FF00.
- (b) king marker: code 3 or 4, with lx and ly in [2*CELL_PX/5, CELL_PX-1-2*CELL_PX/5] -> 24'hFFD700.
- (c) piece body: code 1 or 3 -> 24'hFF0000, code 2 or 4 -> 24'h202020, with lx and ly in [CELL_PX/5, CELL_PX-1-CELL_PX/5].
- (d) square: (cx+cy) even -> 24'hF0D9B5, odd -> 24'hB58863.
REQ-023 SHALL draw codes 0, 5, 6 and 7 as an empty square.
REQ-024 SHALL draw no cursor when cursor_x >= N or cursor_y >= N.
REQ-025 SHALL hold wr_en=0 outside SCAN, and SHALL hold wr_addr and wr_data at their last values there.
REQ-026 SHALL give a start-to-first-write latency of 2 cycles: start in cycle t, LATCH in t+1, first write in t+2; done SHALL be high in cycle t+2+(N*CELL_PX)^2.

Reset
REQ-027 SHALL on rst force state IDLE, busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, all counters 0 and snapshot 0.
REQ-028 SHALL abort a redraw when rst is asserted mid-SCAN, with no further writes and no done pulse.
REQ-029 SHALL let rst win over start when both are high in the same cycle.

Configuration
REQ-030 SHALL, when BOARD_RENDERER_AUTO_REDRAW_EN is defined, compare board/cursor against the snapshot in IDLE and enter LATCH on any difference, exactly as if start were asserted.
REQ-031 SHALL trigger a single redraw when start and an auto-detected difference occur in the same cycle.
REQ-032 SHALL, when BOARD_RENDERER_AUTO_REDRAW_EN is undefined, redraw only on start and synthesise no comparator.

Verification
REQ-033 SHALL pass: defaults, board all 0, cursor (9,9), start at t -> 14400 writes; first wr_addr=20 data F0D9B5; last wr_addr=19179 data F0D9B5; done at t+14402.
REQ-034 SHALL pass: cell (1,0)=001, start -> write at wr_addr=518 (px=18, py=3) data FF0000, and at wr_addr=517 data B58863.
REQ-035 SHALL pass: cell (0,0)=011, cursor (0,0) -> wr_addr=20 data 00FF00; wr_addr=7*160+27 data FFD700; wr_addr=3*160+23 data FF0000.
REQ-036 SHALL pass: start pulsed again at SCAN cycle 100, and board changed at cycle 200 -> exactly 14400 writes, all pixels from the snapshot, one done.
REQ-037 SHALL pass: rst at SCAN cycle 5000 -> wr_en=0 and busy=0 next cycle, no done; with BOARD_RENDERER_AUTO_REDRAW_EN defined and a nonzero board, a redraw starts automatically after rst release.
